// File: rtl/spram_arbiter.sv
// -----------------------------------------------------------------------------
// spram_arbiter
//
// Shares one single-port RAM between the instruction-fetch port (i_*) and the
// load/store port (d_*). At most one request is granted per cycle and the
// granted request drives the RAM directly in that same cycle; there is no
// request buffering. A tag pipeline as deep as the RAM read latency remembers
// which port issued each read, so the returning ram_rdata is steered to the
// right response port.
//
// Parameters
//   AddrBusWidth  address width of both request ports and the RAM
//   DataBusWidth  data width
//   ReadLatency   RAM read latency in cycles, 0..4
//   MaxStall      fetch starvation limit in cycles, 1..255 (fixed priority)
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   i_req_*             fetch read request (valid/ready/addr)
//   i_rsp_*             fetch read response (one-cycle valid pulse + data)
//   d_req_*             load/store request (valid/ready/we/addr/wdata)
//   d_rsp_*             load response (one-cycle valid pulse + data)
//   ram_re/we/addr/wdata  RAM control driven in the grant cycle
//   ram_rdata           RAM read data, valid ReadLatency cycles after ram_re
//
// Configuration
//   SPRAM_ARB_RR_EN defined   : round-robin arbitration (MaxStall ignored)
//   SPRAM_ARB_RR_EN undefined : data port has priority, with a starvation
//                               counter that forces a fetch grant after
//                               MaxStall stalled cycles
// -----------------------------------------------------------------------------
module spram_arbiter #(
   parameter int AddrBusWidth = 32,
   parameter int DataBusWidth = 32,
   parameter int ReadLatency  = 1,
   parameter int MaxStall     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_req_valid,
   output logic                    i_req_ready,
   input  logic [AddrBusWidth-1:0] i_req_addr,
   output logic                    i_rsp_valid,
   output logic [DataBusWidth-1:0] i_rsp_data,
   input  logic                    d_req_valid,
   output logic                    d_req_ready,
   input  logic                    d_req_we,
   input  logic [AddrBusWidth-1:0] d_req_addr,
   input  logic [DataBusWidth-1:0] d_req_wdata,
   output logic                    d_rsp_valid,
   output logic [DataBusWidth-1:0] d_rsp_data,
   output logic                    ram_re,
   output logic                    ram_we,
   output logic [AddrBusWidth-1:0] ram_addr,
   output logic [DataBusWidth-1:0] ram_wdata,
   input  logic [DataBusWidth-1:0] ram_rdata
);

   if ((ReadLatency < 0) || (ReadLatency > 4)) begin : g_bad_latency
      $error("spram_arbiter: ReadLatency must be in 0..4");
   end
   if ((MaxStall < 1) || (MaxStall > 255)) begin : g_bad_max_stall
      $error("spram_arbiter: MaxStall must be in 1..255");
   end

   // A latency of 0 needs no pipeline; keep one unused stage to avoid zero widths.
   localparam int   PipeDepth = (ReadLatency > 0) ? ReadLatency : 1;
   localparam logic OwnerData = 1'b1;

   logic grant_i;
   logic grant_d;
   logic rd_grant;
   logic tail_valid;
   logic tail_owner;

   logic [PipeDepth-1:0]    tag_valid_q, tag_valid_d;
   logic [PipeDepth-1:0]    tag_owner_q, tag_owner_d;
   logic [DataBusWidth-1:0] i_rsp_data_q, i_rsp_data_d;
   logic [DataBusWidth-1:0] d_rsp_data_q, d_rsp_data_d;

`ifdef SPRAM_ARB_RR_EN
   localparam logic PrefData = 1'b0;
   logic rr_ptr_q, rr_ptr_d;

   // Round-robin grant; the pointer only moves when both ports compete.
   always_comb begin
      grant_i  = 1'b0;
      grant_d  = 1'b0;
      rr_ptr_d = rr_ptr_q;
      if (!rst) begin
         rr_ptr_d = PrefData;
      end else if (i_req_valid && d_req_valid) begin
         if (rr_ptr_q == PrefData) begin
            grant_d = 1'b1;
         end else begin
            grant_i = 1'b1;
         end
         rr_ptr_d = ~rr_ptr_q;
      end else if (d_req_valid) begin
         grant_d = 1'b1;
      end else if (i_req_valid) begin
         grant_i = 1'b1;
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      rr_ptr_q <= rr_ptr_d;
   end
`else
   localparam logic [7:0] StallMax = 8'(MaxStall);
   logic [7:0] stall_cnt_q, stall_cnt_d;

   // Data port wins unless the fetch port has been stalled MaxStall cycles.
   always_comb begin
      grant_i     = 1'b0;
      grant_d     = 1'b0;
      stall_cnt_d = stall_cnt_q;
      if (!rst) begin
         stall_cnt_d = 8'd0;
      end else begin
         if (d_req_valid && !(i_req_valid && (stall_cnt_q == StallMax))) begin
            grant_d = 1'b1;
         end else if (i_req_valid) begin
            grant_i = 1'b1;
         end else begin
            grant_i = 1'b0;
         end
         if (!i_req_valid || grant_i) begin
            stall_cnt_d = 8'd0;
         end else if (stall_cnt_q != StallMax) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
         end else begin
            stall_cnt_d = stall_cnt_q;
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      stall_cnt_q <= stall_cnt_d;
   end
`endif

   // Drive the RAM and the ready handshakes from the winning request.
   always_comb begin
      i_req_ready = grant_i;
      d_req_ready = grant_d;
      ram_re      = grant_i | (grant_d & ~d_req_we);
      ram_we      = grant_d & d_req_we;
      rd_grant    = grant_i | (grant_d & ~d_req_we);
      if (grant_i) begin
         ram_addr = i_req_addr;
      end else if (grant_d) begin
         ram_addr = d_req_addr;
      end else begin
         ram_addr = {AddrBusWidth{1'b0}};
      end
      if (grant_d && d_req_we) begin
         ram_wdata = d_req_wdata;
      end else begin
         ram_wdata = {DataBusWidth{1'b0}};
      end
   end

   // Tag pipeline: stage 0 takes the current read grant, the rest shift along.
   always_comb begin
      if (!rst) begin
         tag_valid_d = {PipeDepth{1'b0}};
         tag_owner_d = {PipeDepth{1'b0}};
      end else begin
         tag_valid_d = PipeDepth'({tag_valid_q, rd_grant});
         tag_owner_d = PipeDepth'({tag_owner_q, grant_d});
      end
   end

   if (ReadLatency == 0) begin : g_tail_comb
      assign tail_valid = rd_grant;
      assign tail_owner = grant_d;
   end else begin : g_tail_reg
      assign tail_valid = tag_valid_q[PipeDepth-1];
      assign tail_owner = tag_owner_q[PipeDepth-1];
   end

   // Steer the returning read data to its owner; the other port holds its data.
   always_comb begin
      i_rsp_valid = 1'b0;
      d_rsp_valid = 1'b0;
      i_rsp_data  = i_rsp_data_q;
      d_rsp_data  = d_rsp_data_q;
      if (rst && tail_valid) begin
         if (tail_owner == OwnerData) begin
            d_rsp_valid = 1'b1;
            d_rsp_data  = ram_rdata;
         end else begin
            i_rsp_valid = 1'b1;
            i_rsp_data  = ram_rdata;
         end
      end else begin
         i_rsp_valid = 1'b0;
         d_rsp_valid = 1'b0;
      end
      if (!rst) begin
         i_rsp_data_d = {DataBusWidth{1'b0}};
         d_rsp_data_d = {DataBusWidth{1'b0}};
      end else begin
         i_rsp_data_d = i_rsp_data;
         d_rsp_data_d = d_rsp_data;
      end
   end

   // Tag pipeline and held response data registers.
   always_ff @(posedge clk) begin
      tag_valid_q  <= tag_valid_d;
      tag_owner_q  <= tag_owner_d;
      i_rsp_data_q <= i_rsp_data_d;
      d_rsp_data_q <= d_rsp_data_d;
   end

endmodule

// File: tb/tb_spram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spram_arbiter
//
// Self-checking bench for spram_arbiter (ReadLatency=2, MaxStall=4). A RAM
// model with a two-stage read pipeline is driven from the bench process. A
// reference model (arbitration rule, shadow memory and a queue of expected
// responses stamped with their due cycle) predicts every output each cycle.
// Directed sequences and a stimulus table cover the documented corner cases,
// followed by randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_spram_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int RL = 2;
   localparam int MS = 4;

   logic          clk;
   logic          rst;
   logic          i_req_valid, i_req_ready, i_rsp_valid;
   logic [AW-1:0] i_req_addr;
   logic [DW-1:0] i_rsp_data;
   logic          d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
   logic [AW-1:0] d_req_addr;
   logic [DW-1:0] d_req_wdata, d_rsp_data;
   logic          ram_re, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;

   spram_arbiter #(
      .AddrBusWidth(AW), .DataBusWidth(DW), .ReadLatency(RL), .MaxStall(MS)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
      .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
      .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          port;   // 1 = data port
      logic [DW-1:0] data;
      int            due;
   } rsp_t;

   typedef struct {
      logic iv;
      logic dv;
      logic dwe;
      logic ei;
      logic ed;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // RAM contents and read pipeline (owned by the bench process)
   logic [DW-1:0] mem    [0:63];
   logic [DW-1:0] rd_pipe[0:1];

   // reference model state
   logic [DW-1:0] shadow [0:63];
   rsp_t          exp_q[$];
   logic [DW-1:0] m_held_i, m_held_d;
   logic          m_held_known;
   int            m_stall;
   logic          m_ptr_fetch;

   // samples taken at the negative edge of the last executed cycle
   logic          s_i_ready, s_d_ready, s_re, s_we, s_iv, s_dv;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata, s_id, s_dd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      a = $urandom;
      a = (a & 32'hFFFF_FFC0) | AW'($urandom_range(0, 63));
      return a;
   endfunction

   // One clock cycle: sample and check at negedge, then advance RAM and model.
   task run_cycle();
      logic          egi, egd, ere, ewe, ev_i, ev_d;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] ewd, ed_i, ed_d;
      rsp_t          e;
      @(negedge clk);
      s_i_ready = i_req_ready; s_d_ready = d_req_ready;
      s_re = ram_re; s_we = ram_we; s_addr = ram_addr; s_wdata = ram_wdata;
      s_iv = i_rsp_valid; s_dv = d_rsp_valid; s_id = i_rsp_data; s_dd = d_rsp_data;

      egi = 1'b0; egd = 1'b0;
      if (rst) begin
`ifdef SPRAM_ARB_RR_EN
         if (i_req_valid && d_req_valid) begin
            egi = m_ptr_fetch; egd = !m_ptr_fetch;
         end else begin
            egd = d_req_valid; egi = i_req_valid && !d_req_valid;
         end
`else
         if (i_req_valid && (!d_req_valid || m_stall >= MS)) egi = 1'b1;
         else if (d_req_valid) egd = 1'b1;
`endif
      end
      ere   = egi || (egd && !d_req_we);
      ewe   = egd && d_req_we;
      eaddr = egi ? i_req_addr : (egd ? d_req_addr : 32'h0);
      ewd   = ewe ? d_req_wdata : 32'h0;
      if (ere) exp_q.push_back('{egd, shadow[eaddr[5:0]], cyc + RL});

      ev_i = 1'b0; ev_d = 1'b0; ed_i = m_held_i; ed_d = m_held_d;
      if (rst && exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         if (e.port) begin ev_d = 1'b1; ed_d = e.data; end
         else begin ev_i = 1'b1; ed_i = e.data; end
      end

      chk("i_req_ready", 32'(s_i_ready), 32'(egi));
      chk("d_req_ready", 32'(s_d_ready), 32'(egd));
      chk("ram_re", 32'(s_re), 32'(ere));
      chk("ram_we", 32'(s_we), 32'(ewe));
      chk("ram_addr", s_addr, eaddr);
      chk("ram_wdata", s_wdata, ewd);
      chk("i_rsp_valid", 32'(s_iv), 32'(ev_i));
      chk("d_rsp_valid", 32'(s_dv), 32'(ev_d));
      if (m_held_known) begin
         chk("i_rsp_data", s_id, ed_i);
         chk("d_rsp_data", s_dd, ed_d);
      end

      @(posedge clk);
      #1;
      rd_pipe[1] = rd_pipe[0];
      rd_pipe[0] = s_re ? mem[s_addr[5:0]] : 32'h0BAD_0BAD;
      if (s_we) mem[s_addr[5:0]] = s_wdata;
      ram_rdata = rd_pipe[1];

      if (!rst) begin
         exp_q.delete();
         m_held_i = 32'h0; m_held_d = 32'h0; m_held_known = 1'b1;
         m_stall = 0; m_ptr_fetch = 1'b0;
      end else begin
         if (ev_i) m_held_i = ed_i;
         if (ev_d) m_held_d = ed_d;
         if (ewe) shadow[eaddr[5:0]] = ewd;
         if (!i_req_valid || egi) m_stall = 0;
         else if (m_stall < MS) m_stall++;
         if (i_req_valid && d_req_valid) m_ptr_fetch = egd;
      end
      cyc++;
   endtask

   task set_idle();
      i_req_valid = 1'b0; i_req_addr = 32'h0;
      d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 32'h0; d_req_wdata = 32'h0;
   endtask

   initial begin
      vec_t tbl[6];
      int   pulses;
      logic [DW-1:0] got;

      // arbitration table: both ports valid, data port reading
      for (int k = 0; k < 6; k++) begin
`ifdef SPRAM_ARB_RR_EN
         tbl[k] = '{1'b1, 1'b1, 1'b0, (k % 2) == 1, (k % 2) == 0};
`else
         tbl[k] = '{1'b1, 1'b1, 1'b0, k == 4, k != 4};
`endif
      end

      for (int k = 0; k < 64; k++) begin
         mem[k] = $urandom;
         if (k == 16) mem[k] = 32'hDEAD_BEEF;
         shadow[k] = mem[k];
      end
      rd_pipe[0] = 32'h0; rd_pipe[1] = 32'h0; ram_rdata = 32'h0;
      m_held_i = 32'h0; m_held_d = 32'h0; m_held_known = 1'b0;
      m_stall = 0; m_ptr_fetch = 1'b0;
      set_idle();
      rst = 1'b0;
      #1;

      // reset held for 3 cycles with both requests valid
      i_req_valid = 1'b1; i_req_addr = 32'h10;
      d_req_valid = 1'b1; d_req_addr = 32'h24;
      for (int k = 0; k < 3; k++) begin
         run_cycle();
         chk("rst_i_ready", 32'(s_i_ready), 32'h0);
         chk("rst_d_ready", 32'(s_d_ready), 32'h0);
         chk("rst_ram_re", 32'(s_re | s_we), 32'h0);
         chk("rst_rsp_valid", 32'(s_iv | s_dv), 32'h0);
      end
      rst = 1'b1;
      set_idle();

      // single fetch of 0x10, result two cycles later
      i_req_valid = 1'b1; i_req_addr = 32'h10;
      run_cycle();
      chk("fetch_ready", 32'(s_i_ready), 32'h1);
      set_idle();
      run_cycle();
      chk("fetch_early", 32'(s_iv), 32'h0);
      run_cycle();
      chk("fetch_rsp_valid", 32'(s_iv), 32'h1);
      chk("fetch_rsp_data", s_id, 32'hDEAD_BEEF);
      chk("fetch_no_d_rsp", 32'(s_dv), 32'h0);

      // write 0x20 then read it back the next cycle
      d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h20; d_req_wdata = 32'h1234_5678;
      run_cycle();
      chk("wr_ready", 32'(s_d_ready), 32'h1);
      d_req_we = 1'b0; d_req_wdata = 32'h0;
      pulses = 0; got = 32'h0;
      for (int k = 0; k < 5; k++) begin
         run_cycle();
         if (k == 0) set_idle();
         if (s_dv) begin pulses++; got = s_dd; end
      end
      chk("raw_pulses", 32'(pulses), 32'h1);
      chk("raw_data", got, 32'h1234_5678);

      // contention table after a fresh reset
      rst = 1'b0; run_cycle(); rst = 1'b1;
      i_req_addr = 32'h30;
      for (int k = 0; k < 6; k++) begin
         i_req_valid = tbl[k].iv; d_req_valid = tbl[k].dv; d_req_we = tbl[k].dwe;
         d_req_addr = 32'h100 + 32'(k);
         run_cycle();
         chk("tbl_i_ready", 32'(s_i_ready), 32'(tbl[k].ei));
         chk("tbl_d_ready", 32'(s_d_ready), 32'(tbl[k].ed));
      end
      set_idle();
      for (int k = 0; k < 4; k++) run_cycle();

      // fetch granted, then reset for one cycle: its response must vanish
      i_req_valid = 1'b1; i_req_addr = 32'h10;
      run_cycle();
      chk("mid_fetch_ready", 32'(s_i_ready), 32'h1);
      set_idle();
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         run_cycle();
         rst = 1'b1;
         if (s_iv) pulses++;
      end
      chk("mid_reset_no_rsp", 32'(pulses), 32'h0);

      // randomized traffic that honours the hold-until-ready rule
      for (int k = 0; k < 600; k++) begin
         if (!(i_req_valid && !s_i_ready)) begin
            i_req_valid = ($urandom_range(0, 3) != 0);
            i_req_addr  = rand_addr();
         end
         if (!(d_req_valid && !s_d_ready)) begin
            d_req_valid = ($urandom_range(0, 2) != 0);
            d_req_we    = ($urandom_range(0, 2) == 0);
            d_req_addr  = rand_addr();
            d_req_wdata = $urandom;
         end
         rst = ($urandom_range(0, 59) != 0);
         run_cycle();
      end
      rst = 1'b1;
      set_idle();
      for (int k = 0; k < 4; k++) run_cycle();
      chk("drain_queue", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
